// File: rtl/apb_pkg.sv
// apb_pkg: shared APB bus types and arbiter FSM states
package apb_pkg;
    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;
    typedef logic [3:0]  strb_t;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
endpackage

// File: rtl/apb_rr_arb2.sv
// apb_rr_arb2: two-way round-robin grant; last_i is the index granted last time
module apb_rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);
    // a lone requester always wins; on contention the port not granted last wins
    always_comb begin
        gnt_o[0] = req_i[0] & (~req_i[1] | last_i);
        gnt_o[1] = req_i[1] & (~req_i[0] | ~last_i);
    end
endmodule

// File: rtl/apb_arb.sv
// apb_arb: two-requester round-robin APB master, one transfer in flight; APB_ARB_TIMEOUT_EN adds a PREADY timeout abort
module apb_arb
    import apb_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic           PCLK,
    input  logic           PRESETn,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  addr_t [1:0]    req_addr,
    input  logic  [1:0]    req_write,
    input  data_t [1:0]    req_wdata,
    input  strb_t [1:0]    req_strb,
    output logic [1:0]     rsp_valid,
    output data_t          rsp_rdata,
    output logic           rsp_err,
    output logic           PSEL,
    output logic           PENABLE,
    output logic           PWRITE,
    output addr_t          PADDR,
    output data_t          PWDATA,
    output strb_t          PSTRB,
    input  logic           PREADY,
    input  logic           PSLVERR,
    input  data_t          PRDATA
);
    if (TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("TIMEOUT_CYC must be at least 1");
    end

    state_t     state_q, state_d;
    logic       last_q, gsel_q;
    logic [1:0] gnt;
    logic       accept, sel, fin, abort;

    apb_rr_arb2 u_rr (
        .req_i  (req_valid),
        .last_i (last_q),
        .gnt_o  (gnt)
    );

`ifdef APB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] cnt_q;
    assign abort = (state_q == ACCESS) && !PREADY && (cnt_q == CW'(TIMEOUT_CYC));
    // wait counter: zeroed during SETUP so it starts at 0 on entering ACCESS
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) cnt_q <= '0;
        else if (state_q == SETUP) cnt_q <= '0;
        else if (state_q == ACCESS && !PREADY) cnt_q <= cnt_q + 1'b1;
    end
`else
    assign abort = 1'b0;
`endif

    // grant is only offered while idle; a transfer ends on PREADY or on timeout
    always_comb begin
        req_ready = (state_q == IDLE) ? gnt : 2'b00;
        accept    = |req_ready;
        sel       = req_ready[1];
        fin       = (state_q == ACCESS) && (PREADY || abort);
    end

    // next-state: IDLE -> SETUP on accept, SETUP -> ACCESS, ACCESS -> IDLE on finish
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? SETUP : IDLE;
            SETUP:   state_d = ACCESS;
            ACCESS:  state_d = fin ? IDLE : ACCESS;
            default: state_d = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state_q <= IDLE;
        else state_q <= state_d;
    end

    // APB outputs load on accept and hold through ACCESS; responses register on finish
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            last_q    <= 1'b1;
            gsel_q    <= 1'b0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            PSTRB     <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            PSEL      <= state_d != IDLE;
            PENABLE   <= state_d == ACCESS;
            rsp_valid <= '0;
            if (accept) begin
                last_q <= sel;
                gsel_q <= sel;
                PWRITE <= req_write[sel];
                PADDR  <= req_addr[sel];
                PWDATA <= req_write[sel] ? req_wdata[sel] : '0;
                PSTRB  <= req_write[sel] ? req_strb[sel] : '0;
            end
            if (fin) begin
                rsp_valid[gsel_q] <= 1'b1;
                rsp_rdata         <= (PREADY && !PWRITE) ? PRDATA : '0;
                rsp_err           <= PREADY ? PSLVERR : 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_apb_arb.sv
// tb_apb_arb: randomized scoreboard bench for apb_arb (timeout checks when APB_ARB_TIMEOUT_EN is defined)
module tb_apb_arb;
    import apb_pkg::*;
`ifdef APB_ARB_TIMEOUT_EN
    localparam int T = 4;
`else
    localparam int T = 16;
`endif
    localparam int N = 4096;

    typedef struct {
        int     port;
        addr_t  addr;
        logic   wr;
        data_t  wdata;
        strb_t  strb;
        int     waits;
        data_t  rdata;
        logic   err;
        data_t  exp_rdata;
        logic   exp_err;
        longint due;
    } txn_t;

    logic       PCLK = 1'b0, PRESETn = 1'b0;
    logic [1:0] req_valid = '0, req_write = '0, req_ready, rsp_valid;
    addr_t [1:0] req_addr = '0;
    data_t [1:0] req_wdata = '0;
    strb_t [1:0] req_strb = '0;
    data_t      rsp_rdata, PWDATA, PRDATA = '0;
    logic       rsp_err, PSEL, PENABLE, PWRITE, PREADY = 1'b0, PSLVERR = 1'b0;
    addr_t      PADDR;
    strb_t      PSTRB;

    txn_t   txq [N];
    int     n_cmp = 0, n_bad = 0, n_push = 0, n_pop = 0, pct = 100, last_g = 1;
    int     issued [2] = '{0, 0};
    int     acc_cnt [2] = '{0, 0};
    int     rsp_cnt [2] = '{0, 0};
    longint cyc = 0, busy_until = 0;
    bit     run = 0, saw_access = 0, fin_req = 0, fin_done = 0;
    data_t  last_rdata = '0;
    logic   last_err = 1'b0;

    apb_arb #(.TIMEOUT_CYC(T)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_write(req_write), .req_wdata(req_wdata), .req_strb(req_strb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
    );

    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // requesters: hold valid until accepted, then wait for own response before the next request
    initial begin
        forever begin
            @(posedge PCLK);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (!PRESETn) begin
                    req_valid[i] = 1'b0;
                    issued[i] = 0;
                end else if (req_valid[i]) begin
                    if (acc_cnt[i] == issued[i]) req_valid[i] = 1'b0;
                end else if (run && rsp_cnt[i] == issued[i] && $urandom_range(0, 99) < pct) begin
                    req_valid[i] = 1'b1;
                    issued[i]++;
                    req_addr[i]  = $urandom;
                    req_write[i] = 1'($urandom);
                    req_wdata[i] = $urandom;
                    req_strb[i]  = 4'($urandom);
                end
            end
        end
    end

    // reference model: round-robin winner, idle-until-response timing, expected response pushed per accept
    always @(negedge PCLK) begin : model
        int w;
        logic [1:0] exp_rdy;
        logic ab;
        txn_t t;
        if (!PRESETn) begin
            busy_until = 0;
            last_g = 1;
            n_push = 0;
            acc_cnt = '{0, 0};
        end else begin
            exp_rdy = 2'b00;
            w = 0;
            if (cyc >= busy_until && req_valid != 2'b00) begin
                w = (req_valid == 2'b11) ? 1 - last_g : (req_valid[1] ? 1 : 0);
                exp_rdy[w] = 1'b1;
            end
            check("req_ready", req_ready, exp_rdy);
            if (exp_rdy != 2'b00) begin
                t.port  = w;
                t.addr  = req_addr[w];
                t.wr    = req_write[w];
                t.wdata = req_wdata[w];
                t.strb  = req_strb[w];
                t.waits = ($urandom_range(0, 7) == 0) ? $urandom_range(0, T + 3) : $urandom_range(0, 3);
                t.rdata = $urandom;
                t.err   = ($urandom_range(0, 3) == 0);
`ifdef APB_ARB_TIMEOUT_EN
                ab = t.waits > T;
`else
                ab = 1'b0;
`endif
                t.due       = cyc + 3 + (ab ? T : t.waits);
                t.exp_rdata = (ab || t.wr) ? '0 : t.rdata;
                t.exp_err   = ab ? 1'b1 : t.err;
                txq[n_push % N] = t;
                n_push++;
                busy_until = t.due;
                last_g = w;
                acc_cnt[w]++;
            end
        end
    end

    // APB slave: checks the address phase fields and drives PREADY after the planned wait count
    always @(negedge PCLK) begin : slave
        txn_t t;
        int k;
        if (PRESETn && PSEL) begin
            t = txq[n_pop % N];
            check("paddr", PADDR, t.addr);
            check("pwrite", PWRITE, t.wr);
            check("pwdata", PWDATA, t.wr ? t.wdata : '0);
            check("pstrb", PSTRB, t.wr ? t.strb : '0);
            if (!PENABLE) begin
                k = 0;
                PREADY  = 1'($urandom);
                PRDATA  = $urandom;
                PSLVERR = 1'($urandom);
            end else begin
                PREADY  = (k == t.waits);
                PRDATA  = PREADY ? t.rdata : $urandom;
                PSLVERR = PREADY ? t.err : 1'($urandom);
                k++;
            end
        end else begin
            PREADY  = 1'($urandom);
            PRDATA  = $urandom;
            PSLVERR = 1'($urandom);
        end
    end

    // monitor: pops the scoreboard on each response (or when one is overdue) and checks hold/reset values
    always @(negedge PCLK) begin : monitor
        txn_t t;
        bit popped;
        popped = 0;
        if (!PRESETn) begin
            check("rst_ctrl", {PSEL, PENABLE, PWRITE, PSTRB, rsp_valid, rsp_err}, '0);
            check("rst_paddr", PADDR, '0);
            check("rst_pwdata", PWDATA, '0);
            check("rst_rsp_rdata", rsp_rdata, '0);
            n_pop = 0;
            rsp_cnt = '{0, 0};
            last_rdata = '0;
            last_err = 1'b0;
        end else begin
            if (n_pop != n_push) begin
                t = txq[n_pop % N];
                if (rsp_valid != 2'b00 || cyc >= t.due) begin
                    check("rsp_valid", rsp_valid, 2'b01 << t.port);
                    check("rsp_cycle", cyc, t.due);
                    check("rsp_rdata", rsp_rdata, t.exp_rdata);
                    check("rsp_err", rsp_err, t.exp_err);
                    last_rdata = t.exp_rdata;
                    last_err = t.exp_err;
                    rsp_cnt[t.port]++;
                    n_pop++;
                    popped = 1;
                end
            end else if (rsp_valid != 2'b00) begin
                check("rsp_unexpected", rsp_valid, 2'b00);
                popped = 1;
            end
            if (!popped) check("rsp_hold", {rsp_err, rsp_rdata}, {last_err, last_rdata});
        end
        if (fin_req && !fin_done) begin
            check("drain", n_pop, n_push);
            check("reset_hit_access", saw_access, 1);
            fin_done = 1;
        end
    end

    initial begin
        repeat (3) @(negedge PCLK);
        #1;
        PRESETn = 1'b1;
        run = 1;
        pct = 100;
        repeat (60) @(posedge PCLK);
        pct = 40;
        repeat (1500) @(posedge PCLK);
        for (int i = 0; i < 200 && !saw_access; i++) begin
            @(posedge PCLK);
            #2;
            if (PSEL && PENABLE) saw_access = 1;
        end
        if (saw_access) begin
            PRESETn = 1'b0;
            repeat (2) @(posedge PCLK);
            @(negedge PCLK);
            #1;
            PRESETn = 1'b1;
        end
        pct = 100;
        repeat (40) @(posedge PCLK);
        pct = 40;
        repeat (400) @(posedge PCLK);
        run = 0;
        for (int i = 0; i < 300 && (n_pop != n_push || req_valid != 2'b00); i++) @(posedge PCLK);
        fin_req = 1;
        for (int i = 0; i < 10 && !fin_done; i++) @(posedge PCLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
